// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle command master.
// Queued write/read/poll commands run one at a time on the bus. Each command
// yields exactly one response. Poll re-reads until a masked match, rty causes
// a re-issue, and a bus cycle that stays silent too long is abandoned.
module wb_cmd_master #(
  parameter int ADR_W     = 32,
  parameter int DAT_W     = 32,
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 256,
  parameter int RETRY_MAX = 4,
  parameter int POLL_MAX  = 16,
  parameter int POLL_GAP  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [ADR_W-1:0]       cmd_adr,
  input  logic [DAT_W-1:0]       cmd_dat,
  input  logic [DAT_W-1:0]       cmd_mask,
  input  logic [DAT_W/8-1:0]     cmd_sel,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DAT_W-1:0]       rsp_dat,
  output logic [1:0]             rsp_status,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [ADR_W-1:0]       wb_adr_o,
  output logic [DAT_W-1:0]       wb_dat_o,
  input  logic [DAT_W-1:0]       wb_dat_i,
  output logic [DAT_W/8-1:0]     wb_sel_o,
  output logic                   wb_we_o,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i,
  input  logic                   wb_rty_i
);

  localparam int SEL_W = DAT_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = $clog2(RETRY_MAX + 2);
  localparam int POL_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W = $clog2(POLL_GAP + 2);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_POLL  = 2'b10;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_ERR  = 2'b01;
  localparam logic [1:0] ST_TMO  = 2'b10;
  localparam logic [1:0] ST_POLL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RSP, S_GAP} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [DAT_W-1:0] mask;
    logic [SEL_W-1:0] sel;
  } cmd_t;

  // ---------------------------------------------------------------- FIFO
  cmd_t             mem_q [DEPTH];
  cmd_t             cmd_in;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, full;

  state_t           state_q, state_d;

  assign cmd_in    = '{op: cmd_op, adr: cmd_adr, dat: cmd_dat, mask: cmd_mask, sel: cmd_sel};
  assign full      = (count_q == CNT_W'(DEPTH));
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign cmd_ready = !full || pop;
  assign push      = cmd_valid && cmd_ready;

  // Pointer and occupancy update for push/pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves one unassigned infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  // Command storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; the pointers and count alone define which entries are valid.
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // FIFO pointer and count registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------- FSM
  cmd_t             cur_q, cur_d;
  logic             cyc_q, cyc_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [POL_W-1:0] poll_q, poll_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic             poll_match;

  assign poll_match = ((wb_dat_i ^ cur_q.dat) & cur_q.mask) == '0;

  // Next state, bus strobe and response contents.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    cyc_d        = cyc_q;
    retry_d      = retry_q;
    poll_d       = poll_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cur_d        = mem_q[rd_ptr_q];
          retry_d      = '0;
          poll_d       = '0;
          tmo_d        = '0;
          rsp_dat_d    = '0;
          rsp_status_d = ST_OK;
          cyc_d        = 1'b1;
          state_d      = S_BUS;
        end
      end
      S_BUS: begin
        if (wb_err_i) begin
          cyc_d        = 1'b0;
          rsp_status_d = ST_ERR;
          state_d      = S_RSP;
        end else if (wb_ack_i) begin
          cyc_d = 1'b0;
          if (cur_q.op == OP_WRITE) begin
            rsp_status_d = ST_OK;
            state_d      = S_RSP;
          end else if (cur_q.op == OP_POLL) begin
            rsp_dat_d = wb_dat_i;
            if (poll_match) begin
              rsp_status_d = ST_OK;
              state_d      = S_RSP;
            end else if (poll_q == POL_W'(POLL_MAX - 1)) begin
              rsp_status_d = ST_POLL;
              state_d      = S_RSP;
            end else begin
              poll_d  = poll_q + POL_W'(1);
              gap_d   = GAP_W'(POLL_GAP);
              state_d = S_GAP;
            end
          end else begin
            // Read, and the reserved opcode which behaves as a read.
            rsp_dat_d    = wb_dat_i;
            rsp_status_d = ST_OK;
            state_d      = S_RSP;
          end
        end else if (wb_rty_i) begin
          cyc_d = 1'b0;
          if (retry_q < RTY_W'(RETRY_MAX)) begin
            retry_d = retry_q + RTY_W'(1);
            gap_d   = GAP_W'(1);
            state_d = S_GAP;
          end else begin
            rsp_status_d = ST_ERR;
            state_d      = S_RSP;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          cyc_d        = 1'b0;
          rsp_status_d = ST_TMO;
          state_d      = S_RSP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_GAP: begin
        // gap_q holds the remaining idle cycles; the last one re-raises the strobe.
        if (gap_q <= GAP_W'(1)) begin
          cyc_d   = 1'b1;
          tmo_d   = '0;
          state_d = S_BUS;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, latched command and bus/response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      cyc_q        <= 1'b0;
      retry_q      <= '0;
      poll_q       <= '0;
      tmo_q        <= '0;
      gap_q        <= '0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      cyc_q        <= cyc_d;
      retry_q      <= retry_d;
      poll_q       <= poll_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = cyc_q && (cur_q.op == OP_WRITE);
  assign wb_adr_o   = cur_q.adr;
  assign wb_dat_o   = cur_q.dat;
  assign wb_sel_o   = cur_q.sel;
  assign rsp_valid  = (state_q == S_RSP);
  assign rsp_dat    = rsp_dat_q;
  assign rsp_status = rsp_status_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios plus random
// commands against a scripted Wishbone slave and a command-level model.
module tb_wb_cmd_master;

  localparam int ADR_W = 32, DAT_W = 32, DEPTH = 8, TIMEOUT = 256;
  localparam int RETRY_MAX = 4, POLL_MAX = 16, POLL_GAP = 8;
  localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_POLL = 2'b10;
  localparam logic [1:0] ST_OK = 2'b00, ST_ERR = 2'b01, ST_TMO = 2'b10, ST_PX = 2'b11;
  localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_BOTH = 3;
  localparam int NO_RESP = 100000;

  logic             clk, rst;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_adr, cmd_dat, cmd_mask;
  logic [3:0]       cmd_sel;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_dat;
  logic [1:0]       rsp_status;
  logic             busy;
  logic [3:0]       fifo_count;
  logic [31:0]      wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]       wb_sel_o;
  logic             wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i;

  wb_cmd_master #(
    .ADR_W(ADR_W), .DAT_W(DAT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT),
    .RETRY_MAX(RETRY_MAX), .POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_mask(cmd_mask), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_status(rsp_status), .busy(busy), .fifo_count(fifo_count),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [1:0] op; logic [31:0] adr, dat, mask; logic [3:0] sel; } tcmd_t;
  // One slave reply per bus cycle: kind, stb-high cycle index it fires on, read data.
  typedef struct { int kind; int wt; logic [31:0] data; } rep_t;
  typedef struct { logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat; int gap; int hi; } bus_t;
  typedef struct { logic [1:0] st; logic [31:0] dat; } rsp_t;

  rep_t  rep[$];
  bus_t  exp_bus[$];
  rsp_t  exp_rsp[$];
  int    m_idx = 0, s_idx = 0;
  int    total = 0, bad = 0;
  int    bus_cycles = 0, rsp_seen = 0, last_hi = 0;
  logic [1:0]  last_st;
  logic [31:0] last_dat;
  int    rsp_mode = 1;  // 0: hold low, 1: hold high, 2: random

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic add_rep(input int kind, input int wt, input logic [31:0] data);
    rep.push_back('{kind: kind, wt: wt, data: data});
  endtask

  // Command-level reference: walks the reply script in bus-cycle order and
  // predicts every bus cycle and the final response.
  task automatic model_cmd(input tcmd_t c);
    int retries = 0, polls = 0, gap = -1, hi;
    logic [31:0] data = '0;
    logic [1:0]  st = ST_OK;
    bit done = 0;
    rep_t r;
    while (!done) begin
      if (m_idx >= rep.size()) begin
        $display("FAIL model_reply_script: index %0d beyond %0d", m_idx, rep.size());
        $fatal(1);
      end
      r = rep[m_idx];
      m_idx++;
      hi = (r.wt >= TIMEOUT) ? TIMEOUT : r.wt + 1;
      exp_bus.push_back('{adr: c.adr, we: (c.op == OP_WR), sel: c.sel, dat: c.dat, gap: gap, hi: hi});
      if (r.wt >= TIMEOUT) begin
        st = ST_TMO; done = 1;
      end else if (r.kind == K_ERR || r.kind == K_BOTH) begin
        st = ST_ERR; done = 1;
      end else if (r.kind == K_ACK) begin
        if (c.op == OP_WR) begin
          st = ST_OK; done = 1;
        end else if (c.op == OP_POLL) begin
          data = r.data;
          polls++;
          if ((r.data & c.mask) == (c.dat & c.mask)) begin st = ST_OK; done = 1; end
          else if (polls == POLL_MAX) begin st = ST_PX; done = 1; end
          else gap = POLL_GAP;
        end else begin
          data = r.data; st = ST_OK; done = 1;
        end
      end else begin
        if (retries < RETRY_MAX) begin retries++; gap = 1; end
        else begin st = ST_ERR; done = 1; end
      end
    end
    exp_rsp.push_back('{st: st, dat: data});
  endtask

  // Offer one command (called on a falling edge); models it once accepted.
  task automatic push_cmd(input tcmd_t c);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = c.op; cmd_adr = c.adr;
    cmd_dat = c.dat; cmd_mask = c.mask; cmd_sel = c.sel;
    while (!cmd_ready && n < 5000) begin @(negedge clk); n++; end
    check("push_accepted", cmd_ready, 1'b1);
    if (cmd_ready) model_cmd(c);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((exp_rsp.size() != 0 || busy) && n < budget) begin @(negedge clk); n++; end
    check(tag, (exp_rsp.size() == 0) && !busy, 1'b1);
  endtask

  function automatic tcmd_t mk(input logic [1:0] op, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [31:0] mask, input logic [3:0] sel);
    mk = '{op: op, adr: adr, dat: dat, mask: mask, sel: sel};
  endfunction

  // rsp_ready is changed just after the rising edge so the checker sees a settled value.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = (rsp_mode == 2) ? 1'($urandom_range(0, 1)) : (rsp_mode == 1);
    end
  end

  // Scripted slave and bus-cycle monitor.
  initial begin
    bit prev_stb = 0;
    int hi_cnt = 0, gap_cnt = 0, exp_hi = 0;
    rep_t cur = '{kind: K_ACK, wt: 0, data: '0};
    bus_t e;
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
      if (!rst) begin
        prev_stb = 0; hi_cnt = 0; gap_cnt = 0; wb_dat_i = '0;
      end else begin
        check("cyc_eq_stb", wb_cyc_o, wb_stb_o);
        if (wb_stb_o) begin
          if (!prev_stb) begin
            bus_cycles++;
            check("slave_reply_available", s_idx < rep.size(), 1'b1);
            if (s_idx < rep.size()) begin cur = rep[s_idx]; s_idx++; end
            else cur = '{kind: K_ACK, wt: 0, data: '0};
            check("bus_cycle_expected", exp_bus.size() > 0, 1'b1);
            if (exp_bus.size() > 0) begin
              e = exp_bus.pop_front();
              check("bus_adr", wb_adr_o, e.adr);
              check("bus_we", wb_we_o, e.we);
              check("bus_sel", wb_sel_o, e.sel);
              if (e.we) check("bus_wdat", wb_dat_o, e.dat);
              if (e.gap >= 0) check("bus_gap", gap_cnt, e.gap);
              exp_hi = e.hi;
            end
            hi_cnt = 0;
          end
          wb_dat_i = cur.data;
          if (hi_cnt == cur.wt) begin
            wb_ack_i = (cur.kind == K_ACK) || (cur.kind == K_BOTH);
            wb_err_i = (cur.kind == K_ERR) || (cur.kind == K_BOTH);
            wb_rty_i = (cur.kind == K_RTY);
          end
          hi_cnt++;
        end else begin
          wb_dat_i = $urandom;
          if (prev_stb) begin
            check("stb_high_len", hi_cnt, exp_hi);
            last_hi = hi_cnt;
            gap_cnt = 0;
          end
          gap_cnt++;
        end
        prev_stb = wb_stb_o;
      end
    end
  end

  // Response scoreboard: a handshake happens at the next rising edge.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst && rsp_valid && rsp_ready) begin
        rsp_seen++;
        last_st  = rsp_status;
        last_dat = rsp_dat;
        check("rsp_expected", exp_rsp.size() > 0, 1'b1);
        if (exp_rsp.size() > 0) begin
          r = exp_rsp.pop_front();
          check("rsp_status", rsp_status, r.st);
          check("rsp_dat", rsp_dat, r.dat);
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int b0, r0, seen;
    tcmd_t c;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_adr = '0;
    cmd_dat = '0; cmd_mask = '0; cmd_sel = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_we", wb_we_o, 1'b0);
    check("rst_adr", wb_adr_o, '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_status", rsp_status, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_count", fifo_count, '0);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);

    // 1. Write acked on the 2nd strobe cycle; strobe 2 cycles after the push cycle.
    add_rep(K_ACK, 1, 32'hDEAD_BEEF);
    b0 = bus_cycles;
    push_cmd(mk(OP_WR, 32'h04, 32'hA5, '0, 4'h1));
    check("lat_stb_low_1", wb_stb_o, 1'b0);
    @(negedge clk);
    check("lat_stb_high_2", wb_stb_o, 1'b1);
    check("wr_we", wb_we_o, 1'b1);
    wait_done("wr_done", 200);
    check("wr_bus_count", bus_cycles - b0, 1);
    check("wr_status", last_st, ST_OK);
    check("wr_rsp_dat", last_dat, 32'h0);

    // 2. Fill the queue while the first response is stalled, then drain in order.
    rsp_mode = 0;
    for (int i = 0; i <= DEPTH; i++) add_rep(K_ACK, 0, 32'h1000 + 32'(i));
    r0 = rsp_seen;
    for (int i = 0; i <= DEPTH; i++) push_cmd(mk(OP_RD, 32'h100 + 32'(4 * i), '0, '0, 4'hF));
    repeat (3) @(negedge clk);
    check("full_fifo_count", fifo_count, DEPTH);
    check("full_cmd_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b1; cmd_adr = 32'hBAD;
    repeat (4) @(negedge clk);
    check("full_push_ignored", fifo_count, DEPTH);
    cmd_valid = 1'b0;
    rsp_mode = 1;
    wait_done("drain_done", 2000);
    check("drain_rsp_count", rsp_seen - r0, DEPTH + 1);

    // 3. Poll matching on the 4th read.
    for (int i = 0; i < 3; i++) add_rep(K_ACK, 0, 32'h00);
    add_rep(K_ACK, 0, 32'h61);
    b0 = bus_cycles;
    push_cmd(mk(OP_POLL, 32'h14, 32'h01, 32'h01, 4'hF));
    wait_done("poll_done", 500);
    check("poll_bus_count", bus_cycles - b0, 4);
    check("poll_status", last_st, ST_OK);
    check("poll_rsp_dat", last_dat, 32'h61);

    // 4. Poll that never matches.
    for (int i = 0; i < POLL_MAX; i++) add_rep(K_ACK, i % 3, 32'(2 * i));
    b0 = bus_cycles;
    push_cmd(mk(OP_POLL, 32'h18, 32'h01, 32'h01, 4'hF));
    wait_done("pollx_done", 1000);
    check("pollx_bus_count", bus_cycles - b0, POLL_MAX);
    check("pollx_status", last_st, ST_PX);
    check("pollx_rsp_dat", last_dat, 32'(2 * (POLL_MAX - 1)));

    // 5. Retry exhaustion, then simultaneous ack and err.
    for (int i = 0; i <= RETRY_MAX; i++) add_rep(K_RTY, i % 2, '0);
    b0 = bus_cycles;
    push_cmd(mk(OP_RD, 32'h20, '0, '0, 4'h3));
    wait_done("rty_done", 500);
    check("rty_bus_count", bus_cycles - b0, RETRY_MAX + 1);
    check("rty_status", last_st, ST_ERR);
    add_rep(K_BOTH, 0, 32'h55);
    push_cmd(mk(OP_RD, 32'h24, '0, '0, 4'hC));
    wait_done("ackerr_done", 200);
    check("ackerr_status", last_st, ST_ERR);

    // 6. Silent slave times out.
    add_rep(K_ACK, NO_RESP, '0);
    b0 = bus_cycles;
    push_cmd(mk(OP_RD, 32'h28, '0, '0, 4'hF));
    wait_done("tmo_done", 1000);
    check("tmo_bus_count", bus_cycles - b0, 1);
    check("tmo_stb_len", last_hi, TIMEOUT);
    check("tmo_status", last_st, ST_TMO);

    // Reset during a bus cycle with commands queued behind it.
    add_rep(K_ACK, NO_RESP, '0);
    add_rep(K_ACK, 0, 32'h1);
    add_rep(K_ACK, 0, 32'h2);
    push_cmd(mk(OP_RD, 32'h30, '0, '0, 4'hF));
    begin
      int n = 0;
      while (!wb_stb_o && n < 50) begin @(negedge clk); n++; end
    end
    check("mrst_stb_seen", wb_stb_o, 1'b1);
    push_cmd(mk(OP_WR, 32'h34, 32'h11, '0, 4'hF));
    push_cmd(mk(OP_RD, 32'h38, '0, '0, 4'hF));
    check("mrst_queued", fifo_count, 2);
    b0 = bus_cycles; r0 = rsp_seen;
    @(posedge clk); #2 rst = 1'b0;
    exp_rsp.delete(); exp_bus.delete();
    m_idx = rep.size(); s_idx = rep.size();
    @(posedge clk);
    @(negedge clk);
    check("mrst_cyc", wb_cyc_o, 1'b0);
    check("mrst_stb", wb_stb_o, 1'b0);
    check("mrst_fifo_count", fifo_count, '0);
    check("mrst_rsp_valid", rsp_valid, 1'b0);
    check("mrst_busy", busy, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    seen = 0;
    repeat (30) begin @(negedge clk); if (rsp_valid || wb_stb_o) seen++; end
    check("mrst_no_activity", seen, 0);
    check("mrst_rsp_count", rsp_seen - r0, 0);
    check("mrst_bus_count", bus_cycles - b0, 0);
    check("mrst_cmd_ready", cmd_ready, 1'b1);

    // Random commands, random slave replies, random response back-pressure.
    rsp_mode = 2;
    for (int i = 0; i < 40; i++) begin
      while (rep.size() < m_idx + 40) begin
        int k = $urandom_range(0, 99);
        int kind = (k < 5) ? K_ERR : (k < 9) ? K_BOTH : (k < 22) ? K_RTY : K_ACK;
        int wt = (k >= 97) ? NO_RESP : $urandom_range(0, 3);
        add_rep(kind, wt, $urandom);
      end
      c = mk(2'($urandom_range(0, 3)), $urandom, $urandom, 32'($urandom_range(0, 3)), 4'($urandom));
      push_cmd(c);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_done("rand_done", 30000);
    rsp_mode = 1;
    repeat (2) @(negedge clk);
    check("slave_model_sync", s_idx, m_idx);
    check("bus_queue_empty", exp_bus.size(), 0);
    check("final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
